// File: rtl/dmem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package dmem_access_pkg;

    // Byte-address width of the data RAM bus
    localparam int unsigned DATA_RAM_ADDR_W = 17;
    localparam int unsigned XLEN            = 32;

    // Access size encodings (2'b11 is treated as a word)
    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Request fields latched in IDLE (address is kept separately at RAM width)
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            sext;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Number of byte transfers for a given size
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Half needs addr[0]=0, word (incl. 2'b11) needs addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_mem_load_ext.sv
// Sign/zero extension of assembled load bytes to 32 bits.
module mem_load_ext
    import dmem_access_pkg::*;
(
    input  logic [XLEN-1:0] buf_i,
    input  logic [1:0]      size_i,
    input  logic            sext_i,
    output logic [XLEN-1:0] data_o
);

    // Extend from bit 7 (byte) or bit 15 (half); words pass through
    always_comb begin
        data_o = buf_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sext_i & buf_i[7]}},  buf_i[7:0]};
            SZ_HALF: data_o = {{16{sext_i & buf_i[15]}}, buf_i[15:0]};
            default: data_o = buf_i;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// Data-memory access unit: serialises one load/store into byte transfers
// on a byte-wide synchronous RAM and stalls the pipeline until complete.
module dmem_access
    import dmem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = DATA_RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_we_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q,    state_d;
    logic [1:0]        cnt_q,      cnt_d;
    logic [2:0]        nbytes_q,   nbytes_d;
    dmem_req_t         req_q,      req_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       buf_q,      buf_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic              done_q,     done_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_we_q,   ram_we_d;
    logic [31:0]       ext_data;
    logic              unused_addr_hi;

    // Address bits above the RAM width do not participate
    assign unused_addr_hi = ^addr_i[31:ADDR_W];

    // Load byte assembly: byte for the previous cnt arrives during ISSUE,
    // the final byte arrives during WAIT
    always_comb begin
        buf_d = buf_q;
        if (state_q == ST_IDLE && req_i) begin
            buf_d = '0;
        end else if (state_q == ST_ISSUE && !req_q.we && cnt_q != 2'd0) begin
            buf_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_din_i;
        end else if (state_q == ST_WAIT) begin
            buf_d[{nbytes_q[1:0] - 2'd1, 3'b000} +: 8] = ram_din_i;
        end
    end

    mem_load_ext u_load_ext (
        .buf_i  (buf_d),
        .size_i (req_q.size),
        .sext_i (req_q.sext),
        .data_o (ext_data)
    );

    // Next-state and next-output logic; outputs are registered from *_d
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        req_d      = req_q;
        addr_d     = addr_q;
        rdata_d    = '0;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        ram_we_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    req_d    = '{we: we_i, size: size_i, sext: sext_i, wdata: wdata_i};
                    addr_d   = addr_i[ADDR_W-1:0];
                    cnt_d    = 2'd0;
                    nbytes_d = size_nbytes(size_i);
                    if (is_misaligned(size_i, addr_i[1:0])) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        ram_addr_d = addr_i[ADDR_W-1:0];
                        ram_we_d   = we_i;
                        ram_dout_d = wdata_i[7:0];
                    end
                end
            end
            ST_ISSUE: begin
                if ({1'b0, cnt_q} == nbytes_q - 3'd1) begin
                    if (req_q.we) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    ram_addr_d = addr_q + ADDR_W'(cnt_d);
                    ram_we_d   = req_q.we;
                    ram_dout_d = req_q.wdata[{cnt_d, 3'b000} +: 8];
                end
            end
            ST_WAIT: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                rdata_d = ext_data;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            nbytes_q   <= 3'd0;
            req_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // The IDLE term must react to req_i in the same cycle
    assign stallreq_o = (state_q == ST_IDLE && req_i) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    assign rdata_o    = rdata_q;
    assign done_o     = done_q;
    assign misalign_o = misalign_q;
    assign ram_addr_o = ram_addr_q;
    assign ram_dout_o = ram_dout_q;
    assign ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed self-checking bench for dmem_access with a byte-wide RAM model.
module tb_dmem_access;

    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i, we_i, sext_i;
    logic [1:0]    size_i;
    logic [31:0]   addr_i, wdata_i;
    logic [31:0]   rdata_o;
    logic          done_o, misalign_o, stallreq_o;
    logic [AW-1:0] ram_addr_o;
    logic [7:0]    ram_dout_o, ram_din_i;
    logic          ram_we_o;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_log [$];

    int n_cmp = 0;
    int n_mis = 0;

    dmem_access #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .sext_i     (sext_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .misalign_o (misalign_o),
        .stallreq_o (stallreq_o),
        .ram_addr_o (ram_addr_o),
        .ram_dout_o (ram_dout_o),
        .ram_we_o   (ram_we_o),
        .ram_din_i  (ram_din_i)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data valid one cycle after the address
    always @(posedge clk) begin
        if (ram_we_o) begin
            mem[ram_addr_o] <= ram_dout_o;
            wr_log.push_back(ram_addr_o);
        end
        ram_din_i <= mem[ram_addr_o];
    end

    // Issue one request at a negedge (cycle T) and wait for done_o.
    // lat = cycles from T to done (-1 on timeout); stall_cnt counts cycles
    // with stallreq_o high before done; st_done is stallreq_o during done.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd, input bit hold,
                              output int lat, output logic [31:0] rd, output logic mis,
                              output int stall_cnt, output logic st_done);
        @(negedge clk);
        req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
        #1;
        stall_cnt = stallreq_o ? 1 : 0;
        lat = -1; rd = 'x; mis = 'x; st_done = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done_o) begin
                lat = n; rd = rdata_o; mis = misalign_o; st_done = stallreq_o;
                if (!hold) req_i = 1'b0;
                break;
            end
            if (stallreq_o) stall_cnt++;
        end
        if (lat < 0) req_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (rdata_o !== 32'h0) begin n_mis++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        n_cmp++; if (done_o !== 1'b0 || misalign_o !== 1'b0) begin n_mis++; $display("FAIL reset_done_mis: got %b%b want 00", done_o, misalign_o); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_mis++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
        n_cmp++; if (ram_we_o !== 1'b0 || ram_addr_o !== '0 || ram_dout_o !== 8'h0) begin
            n_mis++; $display("FAIL reset_ram: got we=%b addr=%h dout=%h want 0/0/0", ram_we_o, ram_addr_o, ram_dout_o); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        int lat, sc; logic [31:0] rd; logic mis, sd;
        run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 5) begin n_mis++; $display("FAIL sw_latency: got %0d want 5", lat); end
        n_cmp++; if ({mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} !== 32'hDEADBEEF) begin
            n_mis++; $display("FAIL sw_ram: got %h%h%h%h want DEADBEEF", mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]); end
        n_cmp++; if (rd !== 32'h0 || mis !== 1'b0) begin n_mis++; $display("FAIL sw_rdata: got %h mis=%b want 0 mis=0", rd, mis); end
        run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 6) begin n_mis++; $display("FAIL lw_latency: got %0d want 6", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_mis++; $display("FAIL lw_rdata: got %h want DEADBEEF", rd); end
        n_cmp++; if (sc !== 6 || sd !== 1'b0) begin n_mis++; $display("FAIL lw_stall: got cnt=%0d at_done=%b want 6/0", sc, sd); end
    endtask

    task automatic test_byte_ext();
        int lat, sc; logic [31:0] rd; logic mis, sd;
        mem[32'h200] = 8'h80;
        run_access(1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL lb_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_mis++; $display("FAIL lb_rdata: got %h want FFFFFF80", rd); end
        run_access(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL lbu_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'h00000080) begin n_mis++; $display("FAIL lbu_rdata: got %h want 00000080", rd); end
    endtask

    task automatic test_half();
        int lat, sc; logic [31:0] rd; logic mis, sd;
        mem[32'h204] = 8'h5A;
        run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 3) begin n_mis++; $display("FAIL sh_latency: got %0d want 3", lat); end
        n_cmp++; if (mem[32'h202] !== 8'hCD || mem[32'h203] !== 8'hAB || mem[32'h204] !== 8'h5A) begin
            n_mis++; $display("FAIL sh_ram: got %h %h %h want CD AB 5A", mem[32'h202], mem[32'h203], mem[32'h204]); end
        run_access(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL lh_latency: got %0d want 4", lat); end
        n_cmp++; if (rd !== 32'hFFFFABCD) begin n_mis++; $display("FAIL lh_rdata: got %h want FFFFABCD", rd); end
        run_access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (rd !== 32'h0000ABCD) begin n_mis++; $display("FAIL lhu_rdata: got %h want 0000ABCD", rd); end
    endtask

    task automatic test_misalign();
        int lat, sc, w0; logic [31:0] rd; logic mis, sd;
        w0 = wr_log.size();
        run_access(1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 1 || mis !== 1'b1) begin n_mis++; $display("FAIL lw_mis: got lat=%0d mis=%b want 1/1", lat, mis); end
        n_cmp++; if (rd !== 32'h0) begin n_mis++; $display("FAIL lw_mis_rdata: got %h want 0", rd); end
        mem[32'h3] = 8'h77;
        run_access(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFFFFFF, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0) begin
            n_mis++; $display("FAIL sh_mis: got lat=%0d mis=%b rd=%h want 1/1/0", lat, mis, rd); end
        n_cmp++; if (wr_log.size() !== w0 || mem[32'h3] !== 8'h77) begin
            n_mis++; $display("FAIL mis_ram_quiet: got writes=%0d mem3=%h want 0/77", wr_log.size() - w0, mem[32'h3]); end
    endtask

    task automatic test_reset_mid();
        int lat, sc; logic [31:0] rd; logic mis, sd;
        for (int i = 0; i < 4; i++) mem[32'h10 + i] = 8'h00;
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sext_i = 1'b0; addr_i = 32'h10; wdata_i = 32'h44332211;
        repeat (3) @(negedge clk);
        n_cmp++; if (ram_we_o !== 1'b1 || ram_addr_o !== 17'h12) begin
            n_mis++; $display("FAIL rst_mid_pre: got we=%b addr=%h want 1/12", ram_we_o, ram_addr_o); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ram_we_o !== 1'b0) begin n_mis++; $display("FAIL rst_mid_we: got %b want 0", ram_we_o); end
        req_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (stallreq_o !== 1'b0 || done_o !== 1'b0) begin
            n_mis++; $display("FAIL rst_mid_idle: got stall=%b done=%b want 0/0", stallreq_o, done_o); end
        n_cmp++; if ({mem[32'h13], mem[32'h12], mem[32'h11], mem[32'h10]} !== 32'h00002211) begin
            n_mis++; $display("FAIL rst_mid_ram: got %h%h%h%h want 00002211", mem[32'h13], mem[32'h12], mem[32'h11], mem[32'h10]); end
        run_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, lat, rd, mis, sc, sd);
        n_cmp++; if (lat !== 3 || rd !== 32'h00000022) begin
            n_mis++; $display("FAIL rst_mid_after: got lat=%0d rd=%h want 3/00000022", lat, rd); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, sc, w0; logic [31:0] rd; logic mis, sd;
        logic [AW-1:0] exp_a;
        int bad_addr;
        w0 = wr_log.size();
        run_access(1'b1, 2'b10, 1'b0, 32'h1FFFC, 32'hA1B2C3D4, 1'b1, lat1, rd, mis, sc, sd);
        run_access(1'b1, 2'b10, 1'b0, 32'h1FFFC, 32'h55667788, 1'b0, lat2, rd, mis, sc, sd);
        n_cmp++; if (lat1 !== 5 || lat2 !== 5) begin n_mis++; $display("FAIL b2b_latency: got %0d,%0d want 5,5", lat1, lat2); end
        n_cmp++; if (wr_log.size() - w0 !== 8) begin n_mis++; $display("FAIL b2b_count: got %0d writes want 8", wr_log.size() - w0); end
        bad_addr = 0;
        for (int i = 0; i < 8 && (w0 + i) < wr_log.size(); i++) begin
            exp_a = 17'h1FFFC + AW'(i % 4);
            if (wr_log[w0 + i] !== exp_a) bad_addr++;
        end
        n_cmp++; if (bad_addr !== 0) begin n_mis++; $display("FAIL b2b_addr: got %0d wrong addresses want 0", bad_addr); end
        n_cmp++; if ({mem[17'h1FFFF], mem[17'h1FFFE], mem[17'h1FFFD], mem[17'h1FFFC]} !== 32'h55667788) begin
            n_mis++; $display("FAIL b2b_ram: got %h%h%h%h want 55667788", mem[17'h1FFFF], mem[17'h1FFFE], mem[17'h1FFFD], mem[17'h1FFFC]); end
        @(negedge clk);
        n_cmp++; if (stallreq_o !== 1'b0 || done_o !== 1'b0) begin
            n_mis++; $display("FAIL b2b_quiet: got stall=%b done=%b want 0/0", stallreq_o, done_o); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        rst = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sext_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0;
        test_reset();
        test_word_store_load();
        test_byte_ext();
        test_half();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
Name: dmem_access

Overview:
- Data-memory access unit directly downstream of the MEM stage.
- Converts one load/store request (byte/half/word, 32-bit address) into a sequence of byte transfers on a byte-wide synchronous data RAM.
- Holds the pipeline via stallreq_o until the access completes, then returns sign- or zero-extended load data for MEM to forward to MEM/WB.
- Little-endian.

Parameters:
- ADDR_W, 17, width of the byte address presented to the data RAM.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  1  access request from MEM (mem_ce); level, held until done_o.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sext_i  in  1  loads only: 1 sign-extend, 0 zero-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; low bytes used for byte/half.
- rdata_o  out  32  extended load data; valid while done_o=1.
- done_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  with done_o: access rejected as misaligned.
- stallreq_o  out  1  stall request to ctrl.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_dout_o  out  8  RAM write byte.
- ram_we_o  out  1  RAM write enable.
- ram_din_i  in  8  RAM read byte, valid one cycle after its address is presented.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. State, cnt[1:0], nbytes, latched we/size/sext/addr/wdata, and the assembly buffer buf[31:0] are registers.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; cnt and buf clear.
  - rdata_o=0, done_o=0, misalign_o=0, stallreq_o=0, ram_addr_o=0, ram_dout_o=0, ram_we_o=0.
  - A reset mid-access aborts it: no further RAM writes, and bytes already written are not undone.
- IDLE:
  - On req_i=1, latch the request and clear cnt.
  - Misaligned requests go to DONE with misalign_o=1 and never touch the RAM. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise go to ISSUE. nbytes is 1, 2 or 4.
- ISSUE:
  - ram_addr_o = latched addr[ADDR_W-1:0] + cnt, wrapping modulo 2^ADDR_W.
  - Stores: ram_we_o=1 and ram_dout_o = wdata byte cnt.
  - Loads: ram_we_o=0; the byte returned for the previous cnt is captured into buf.
  - cnt increments each cycle. When cnt == nbytes-1: stores go to DONE, loads go to WAIT.
- WAIT (loads only): capture the last byte from ram_din_i, then go to DONE.
- DONE:
  - done_o=1 for exactly one cycle.
  - rdata_o = extension of buf (bit 7 for byte, bit 15 for half); rdata_o=0 for stores and misaligned accesses.
  - Return to IDLE unconditionally. A still-high req_i in that next IDLE cycle is treated as a new request.
- stallreq_o = (state==IDLE && req_i) || state==ISSUE || state==WAIT. It is 0 in DONE so the pipeline advances on that edge.
- Latency from the first req_i cycle T to done_o:
  - word load T+6; half load T+4; byte load T+3.
  - word store T+5; half store T+3; byte store T+2.
  - misaligned T+1.
- ram_we_o is 0 in every state except a store in ISSUE.
- req_i changes while in ISSUE/WAIT are ignored, because the request is latched in IDLE.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding for IDLE/ISSUE/WAIT/DONE;
  - DataRamAddrBus width macro tied to ADDR_W.
- One sub-module, mem_load_ext: purely combinational buf/size/sext to 32-bit extension, instantiated for rdata_o.

Test Plan:
1. Word store then load:
   - Stimulus: SW addr=0x100 wdata=0xDEADBEEF, then LW addr=0x100.
   - Response, store: RAM[0x100..0x103] = EF,BE,AD,DE; done at T+5.
   - Response, load: rdata_o=0xDEADBEEF at T+6; stallreq_o high T..T+5.
2. Byte load extension:
   - Stimulus: RAM[0x200]=0x80; LB (sext=1), then LBU (sext=0).
   - Response: rdata_o=0xFFFFFF80, then 0x00000080; done at T+3.
3. Half store/load:
   - Stimulus: SH addr=0x202 wdata=0x1234ABCD, then LH addr=0x202.
   - Response: RAM[0x202]=0xCD, RAM[0x203]=0xAB; rdata_o=0xFFFFABCD.
4. Misalignment:
   - Stimulus: LW addr=0x101.
   - Response: done_o and misalign_o at T+1, zero RAM activity, rdata_o=0.
   - Also: SH addr=0x3 behaves the same way.
5. Reset mid-access:
   - Stimulus: SW addr=0x10, assert rst low after 2 ISSUE cycles.
   - Response: ram_we_o drops immediately; only RAM[0x10..0x11] are written; after release, state is IDLE and stallreq_o=0.
6. Back-to-back with wrap:
   - Stimulus: req_i held high across two SW at addr=0x1FFFC, ADDR_W=17.
   - Response: two distinct done pulses; ram_addr_o covers 0x1FFFC..0x1FFFF; no dropped or duplicated access.
